// File: rtl/segre_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : segre_hazard_scoreboard
// Description : Per-register pending-write scoreboard for the ID/EX boundary.
//               Tracks the remaining latency of every in-flight producer
//               (ALU, load, M-extension; latency 1..MAX_LAT). It raises RAW,
//               WAW and writeback-port stalls and gives per-operand bypass
//               distance selects. It also sequences the end-of-test drain:
//               latch the finish request, wait until nothing is pending, then
//               raise a sticky finish flag after FINISH_DELAY idle cycles.
//
// Ports       : clk_i, rst_i        clock, synchronous active-high reset
//               issue_valid_i       ID holds a valid instruction
//               src_a_i/src_b_i     source register identifiers
//               rd_src_a_i/_b_i     instruction actually reads the source
//               dst_i, we_i         destination register and write enable
//               lat_i               producer latency (issue to regfile write)
//               hold_i              downstream freeze, all state holds
//               flush_i             ID instruction is discarded this cycle
//               finish_test_i       end-of-test request
//               issue_fire_o        instruction accepted this cycle
//               stall_o             block ID/IF, inject a nop into EX
//               raw_/waw_/wb_stall_o  individual (non-prioritised) causes
//               fwd_a_o/fwd_b_o     remaining cycles of the producer, 0 = RF
//               lat_err_o           lat_i out of range (clamped to MAX_LAT)
//               busy_o              at least one register pending
//               finish_test_o       sticky end-of-test
//
// Revision    : 1.0 - initial release
// ============================================================================
module segre_hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int MAX_LAT      = 5,
    parameter int LAT_W        = 3,
    parameter int BYPASS_LAT   = 1,
    parameter int FINISH_DELAY = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [REG_W-1:0] src_a_i,
    input  logic [REG_W-1:0] src_b_i,
    input  logic             rd_src_a_i,
    input  logic             rd_src_b_i,
    input  logic [REG_W-1:0] dst_i,
    input  logic             we_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             finish_test_i,
    output logic             issue_fire_o,
    output logic             stall_o,
    output logic             raw_stall_o,
    output logic             waw_stall_o,
    output logic             wb_stall_o,
    output logic [LAT_W-1:0] fwd_a_o,
    output logic [LAT_W-1:0] fwd_b_o,
    output logic             lat_err_o,
    output logic             busy_o,
    output logic             finish_test_o
);

    localparam int FIN_W = (FINISH_DELAY < 1) ? 1 : $clog2(FINISH_DELAY + 1);

    localparam logic [LAT_W-1:0] C_MAX_LAT    = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] C_BYPASS_LAT = LAT_W'(BYPASS_LAT);
    localparam logic [LAT_W-1:0] C_LAT_ONE    = LAT_W'(1);
    localparam logic [FIN_W-1:0] C_FIN_DELAY  = FIN_W'(FINISH_DELAY);
    localparam logic [FIN_W-1:0] C_FIN_ONE    = FIN_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Entry 0 exists only so that the array can be indexed directly by a
    // register identifier; it is held at zero so x0 never looks pending.
    logic [LAT_W-1:0]   r_cnt [NUM_REGS];
    // Bit k set: the writeback port is already claimed k+1 cycles from now.
    logic [MAX_LAT-1:0] r_wb_resv;
    logic               r_fin_seen;
    logic [FIN_W-1:0]   r_fin_cnt;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic               w_lat_err;
    logic [LAT_W-1:0]   w_eff_lat;
    logic [MAX_LAT-1:0] w_lat_onehot;
    logic [LAT_W-1:0]   w_cnt_a;
    logic [LAT_W-1:0]   w_cnt_b;
    logic [LAT_W-1:0]   w_cnt_d;
    logic               w_use_a;
    logic               w_use_b;
    logic               w_dst_nz;
    logic               w_haz_a;
    logic               w_haz_b;
    logic               w_raw;
    logic               w_waw;
    logic               w_wb;
    logic               w_stall;
    logic               w_fire;
    logic               w_wr_en;
    logic               w_busy;

    // Out-of-range latencies are treated as the slowest producer so that the
    // result is never forwarded or written back early.
    assign w_lat_err = (lat_i == '0) || (lat_i > C_MAX_LAT);
    assign w_eff_lat = w_lat_err ? C_MAX_LAT : lat_i;

    // Reservation slot that this instruction would claim (bit eff_lat-1).
    assign w_lat_onehot = MAX_LAT'(1) << (w_eff_lat - C_LAT_ONE);

    assign w_cnt_a  = r_cnt[src_a_i];
    assign w_cnt_b  = r_cnt[src_b_i];
    assign w_cnt_d  = r_cnt[dst_i];

    assign w_use_a  = rd_src_a_i && (src_a_i != '0);
    assign w_use_b  = rd_src_b_i && (src_b_i != '0);
    assign w_dst_nz = dst_i != '0;

    // A producer close enough to completion can be forwarded instead of
    // stalling; anything further away is a true RAW hazard.
    assign w_haz_a  = w_use_a && (w_cnt_a > C_BYPASS_LAT);
    assign w_haz_b  = w_use_b && (w_cnt_b > C_BYPASS_LAT);
    assign w_raw    = issue_valid_i && (w_haz_a || w_haz_b);

    // A new write must not complete before (or together with) an older write
    // to the same register.
    assign w_waw    = issue_valid_i && we_i && w_dst_nz && (w_cnt_d >= w_eff_lat);

    assign w_wb     = issue_valid_i && we_i && (|(r_wb_resv & w_lat_onehot));

    // Once the drain has started no further instruction may enter EX.
    assign w_stall  = !flush_i &&
                      (w_raw || w_waw || w_wb || (r_fin_seen && issue_valid_i));

    assign w_fire   = issue_valid_i && !hold_i && !flush_i && !w_stall;
    assign w_wr_en  = w_fire && we_i && w_dst_nz;

    always_comb begin
        w_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (r_cnt[r] != '0) begin
                w_busy = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-register countdown
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (!hold_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0) begin
                    r_cnt[r] <= '0;
                end else if (w_wr_en && (dst_i == REG_W'(r))) begin
                    // A fresh issue overrides the decrement of the old value.
                    r_cnt[r] <= w_eff_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - C_LAT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Writeback-port reservation shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_resv <= '0;
        end else if (!hold_i) begin
            r_wb_resv <= (r_wb_resv >> 1) | (w_wr_en ? w_lat_onehot : '0);
        end
    end

    // ------------------------------------------------------------------------
    // End-of-test drain
    // ------------------------------------------------------------------------
    // fin_cnt only advances on idle cycles and saturates at FINISH_DELAY, so
    // the finish flag derived from it is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fin_seen <= 1'b0;
            r_fin_cnt  <= '0;
        end else if (!hold_i) begin
            if (finish_test_i) begin
                r_fin_seen <= 1'b1;
            end
            if (r_fin_seen && !w_busy && (r_fin_cnt != C_FIN_DELAY)) begin
                r_fin_cnt <= r_fin_cnt + C_FIN_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign issue_fire_o  = w_fire;
    assign stall_o       = w_stall;
    assign raw_stall_o   = w_raw && !flush_i;
    assign waw_stall_o   = w_waw && !flush_i;
    assign wb_stall_o    = w_wb  && !flush_i;
    assign fwd_a_o       = w_use_a ? w_cnt_a : '0;
    assign fwd_b_o       = w_use_b ? w_cnt_b : '0;
    assign lat_err_o     = w_lat_err;
    assign busy_o        = w_busy;
    assign finish_test_o = r_fin_seen && (r_fin_cnt == C_FIN_DELAY);

endmodule
`default_nettype wire

// File: tb/tb_segre_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_hazard_scoreboard
// Description : Self-checking bench for segre_hazard_scoreboard. A reference
//               model keeps an absolute "logical time" (non-hold cycles) and,
//               per register, the time at which its pending write completes,
//               plus the set of writeback slots already claimed. Directed
//               scenarios are followed by a randomized phase and the
//               end-of-test drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_hazard_scoreboard;

    localparam int NUM_REGS     = 32;
    localparam int REG_W        = 5;
    localparam int MAX_LAT      = 5;
    localparam int LAT_W        = 3;
    localparam int BYPASS_LAT   = 1;
    localparam int FINISH_DELAY = 4;

    logic             clk;
    logic             rst;
    logic             iv;
    logic [REG_W-1:0] sa;
    logic [REG_W-1:0] sb;
    logic             rda;
    logic             rdb;
    logic [REG_W-1:0] dst;
    logic             we;
    logic [LAT_W-1:0] lat;
    logic             hold;
    logic             flush;
    logic             fin;

    logic             issue_fire_o;
    logic             stall_o;
    logic             raw_stall_o;
    logic             waw_stall_o;
    logic             wb_stall_o;
    logic [LAT_W-1:0] fwd_a_o;
    logic [LAT_W-1:0] fwd_b_o;
    logic             lat_err_o;
    logic             busy_o;
    logic             finish_test_o;

    segre_hazard_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .REG_W        (REG_W),
        .MAX_LAT      (MAX_LAT),
        .LAT_W        (LAT_W),
        .BYPASS_LAT   (BYPASS_LAT),
        .FINISH_DELAY (FINISH_DELAY)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (iv),
        .src_a_i       (sa),
        .src_b_i       (sb),
        .rd_src_a_i    (rda),
        .rd_src_b_i    (rdb),
        .dst_i         (dst),
        .we_i          (we),
        .lat_i         (lat),
        .hold_i        (hold),
        .flush_i       (flush),
        .finish_test_i (fin),
        .issue_fire_o  (issue_fire_o),
        .stall_o       (stall_o),
        .raw_stall_o   (raw_stall_o),
        .waw_stall_o   (waw_stall_o),
        .wb_stall_o    (wb_stall_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .lat_err_o     (lat_err_o),
        .busy_o        (busy_o),
        .finish_test_o (finish_test_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: absolute completion times and claimed writeback slots
    // ------------------------------------------------------------------------
    int m_now;
    int m_done [NUM_REGS];
    bit m_slot [int];
    bit m_fin;
    int m_idle;
    bit m_fire;

    int n_checks;
    int n_fail;
    int cyc;
    int raw_seen;
    int waw_seen;
    int wb_seen;
    int fire_fwd_a;
    int first_fin;

    function automatic int rem(int r);
        if (r == 0) return 0;
        return (m_done[r] > m_now) ? (m_done[r] - m_now) : 0;
    endfunction

    task automatic model_reset();
        m_now = 0;
        for (int r = 0; r < NUM_REGS; r++) m_done[r] = 0;
        m_slot.delete();
        m_fin  = 1'b0;
        m_idle = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: settle inputs, compare every output with the model, clock,
    // advance the model.
    task automatic cycle();
        int eff, ra, rb, rd, fa, fb;
        bit lerr, ha, hb, raw, waw, wb, stl, fire, busy, fdone;
        #1;
        lerr = (lat == 0) || (int'(lat) > MAX_LAT);
        eff  = lerr ? MAX_LAT : int'(lat);
        ra   = rem(int'(sa));
        rb   = rem(int'(sb));
        rd   = rem(int'(dst));
        ha   = rda && (sa != 0) && (ra > BYPASS_LAT);
        hb   = rdb && (sb != 0) && (rb > BYPASS_LAT);
        raw  = iv && (ha || hb);
        waw  = iv && we && (dst != 0) && (rd >= eff);
        wb   = iv && we && m_slot.exists(m_now + eff);
        stl  = !flush && (raw || waw || wb || (m_fin && iv));
        fire = iv && !hold && !flush && !stl;
        fa   = (rda && sa != 0) ? ra : 0;
        fb   = (rdb && sb != 0) ? rb : 0;
        busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) if (rem(r) > 0) busy = 1'b1;
        fdone = m_fin && (m_idle >= FINISH_DELAY);

        chk("issue_fire", 32'(issue_fire_o), 32'(fire));
        chk("stall",      32'(stall_o),      32'(stl));
        chk("raw_stall",  32'(raw_stall_o),  32'(raw && !flush));
        chk("waw_stall",  32'(waw_stall_o),  32'(waw && !flush));
        chk("wb_stall",   32'(wb_stall_o),   32'(wb && !flush));
        chk("fwd_a",      32'(fwd_a_o),      32'(fa));
        chk("fwd_b",      32'(fwd_b_o),      32'(fb));
        chk("lat_err",    32'(lat_err_o),    32'(lerr));
        chk("busy",       32'(busy_o),       32'(busy));
        chk("finish",     32'(finish_test_o), 32'(fdone));

        if (raw_stall_o === 1'b1) raw_seen++;
        if (waw_stall_o === 1'b1) waw_seen++;
        if (wb_stall_o === 1'b1) wb_seen++;
        if (fire) fire_fwd_a = int'(fwd_a_o);
        if (finish_test_o === 1'b1 && first_fin < 0) first_fin = cyc;
        m_fire = fire;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!hold) begin
            if (m_fin && !busy) m_idle++;
            if (fin) m_fin = 1'b1;
            if (fire && we && dst != 0) begin
                m_done[dst] = m_now + 1 + eff;
                m_slot[m_now + 1 + eff] = 1'b1;
            end
            m_now++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(bit v, int a, bit ua, int b, bit ub, int d, bit w, int l);
        iv  = v;
        sa  = REG_W'(a);
        rda = ua;
        sb  = REG_W'(b);
        rdb = ub;
        dst = REG_W'(d);
        we  = w;
        lat = LAT_W'(l);
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        hold  = 1'b0;
        flush = 1'b0;
        fin   = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Keep presenting the current instruction until the model accepts it.
    task automatic until_fire(int budget);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!m_fire && k < budget);
        n_checks++;
        if (!m_fire) begin
            n_fail++;
            $error("FAIL fire_timeout cycle=%0d observed=no_fire expected=fire", cyc);
        end
    endtask

    initial begin
        int q;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        first_fin  = -1;
        model_reset();
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        fin   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        idle(2);

        // RAW: lat-3 write to x5, reader of x5 right behind it.
        drive(1, 0, 0, 0, 0, 5, 1, 3);
        cycle();
        raw_seen = 0;
        drive(1, 5, 1, 0, 0, 0, 0, 1);
        until_fire(10);
        chk("raw_stall_cycles", 32'(raw_seen), 32'd2);
        chk("raw_fire_fwd_a", 32'(fire_fwd_a), 32'd1);
        idle(6);

        // WAW: lat-5 MUL to x7, lat-1 ADD to x7 next cycle.
        drive(1, 0, 0, 0, 0, 7, 1, 5);
        cycle();
        waw_seen = 0;
        drive(1, 1, 1, 2, 1, 7, 1, 1);
        until_fire(12);
        chk("waw_stall_cycles", 32'(waw_seen), 32'd5);
        idle(6);

        // Writeback port: lat-3 to x1 then lat-2 and lat-3 to x2.
        drive(1, 0, 0, 0, 0, 1, 1, 3);
        cycle();
        drive(1, 0, 0, 0, 0, 2, 1, 2);
        until_fire(8);
        idle(6);
        drive(1, 0, 0, 0, 0, 1, 1, 3);
        cycle();
        wb_seen = 0;
        drive(1, 0, 0, 0, 0, 2, 1, 3);
        until_fire(8);
        chk("wb_stall_cycles", 32'(wb_seen), 32'd1);
        idle(6);

        // Hold: x4 pending, freeze three cycles while a reader watches it.
        drive(1, 0, 0, 0, 0, 4, 1, 3);
        cycle();
        drive(0, 4, 1, 4, 1, 0, 0, 1);
        cycle();
        hold = 1'b1;
        drive(1, 4, 1, 4, 1, 0, 0, 1);
        cycle(); cycle(); cycle();
        hold = 1'b0;
        drive(0, 4, 1, 4, 1, 0, 0, 1);
        cycle(); cycle(); cycle();
        idle(4);

        // Flush over a RAW hazard, then out-of-range latencies.
        drive(1, 0, 0, 0, 0, 9, 1, 5);
        cycle();
        flush = 1'b1;
        drive(1, 9, 1, 9, 1, 9, 1, 2);
        cycle();
        flush = 1'b0;
        drive(1, 0, 0, 0, 0, 10, 1, 0);
        until_fire(10);
        drive(0, 10, 1, 9, 1, 0, 0, 1);
        cycle();
        idle(7);
        drive(1, 0, 0, 0, 0, 12, 1, 7);
        until_fire(10);
        drive(1, 0, 0, 0, 0, 13, 1, 6);
        until_fire(10);
        idle(7);

        // Reset in the middle of activity, with hold asserted.
        drive(1, 0, 0, 0, 0, 11, 1, 5);
        cycle();
        rst  = 1'b1;
        hold = 1'b1;
        drive(0, 11, 1, 0, 0, 0, 0, 1);
        cycle();
        rst  = 1'b0;
        hold = 1'b0;
        cycle();

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7));
            hold  = $urandom_range(0, 99) < 15;
            flush = $urandom_range(0, 99) < 10;
            cycle();
        end
        idle(8);

        // Drain: request finish while x3 has two cycles left.
        drive(1, 0, 0, 0, 0, 3, 1, 2);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        fin = 1'b1;
        q   = cyc;
        cycle();
        fin = 1'b0;
        drive(1, 0, 0, 0, 0, 6, 1, 1);
        for (int i = 0; i < 10; i++) cycle();
        chk("finish_latency", 32'(first_fin - q), 32'd6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
